// File: rtl/cpu_types_pkg.sv
// Shared types for the forwarding producer: register index, in-flight
// destination tag and decode port indices.
package cpu_types_pkg;
  localparam int REG_BITS = 5;
  localparam int PORT_RS  = 0;
  localparam int PORT_RT  = 1;

  typedef logic [REG_BITS-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     load;
  } fwd_tag_t;

  // Register 0 is hardwired, so a tag writing it never produces a value.
  function automatic logic tag_live(input fwd_tag_t t);
    return t.valid && (t.wsel != '0);
  endfunction
endpackage

// File: rtl/fwd_tag_cmp.sv
// Live-and-match test of one in-flight destination tag against one source index.
module fwd_tag_cmp
  import cpu_types_pkg::*;
(
  input  fwd_tag_t tag,
  input  regbits_t src,
  output logic     hit
);
  assign hit = tag_live(tag) && (tag.wsel == src);
endmodule

// File: rtl/forward_detect_unit.sv
// Shadow EX/MEM destination tags feeding the forwarding unit: operand match
// flags for decode and execute, plus the load-use stall and its counter.
module forward_detect_unit
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             adv,
  input  logic             flush,
  input  logic [REG_W-1:0] rs_dec,
  input  logic [REG_W-1:0] rt_dec,
  input  logic             uses_rt_dec,
  input  logic [REG_W-1:0] wsel_dec,
  input  logic             RegWr_dec,
  input  logic             MemtoReg_dec,
  input  logic [REG_W-1:0] rs_ex,
  input  logic [REG_W-1:0] rt_ex,
  output logic             hazard_dec,
  output logic [1:0]       rport_dec,
  output logic [1:0]       sel_mem_dec,
  output logic             hazard_ex,
  output logic [1:0]       rport_ex,
  output logic             MemtoReg_ex,
  output logic             MemtoReg_mem,
  output logic             lu_stall,
  output logic [CNT_W-1:0] stall_cnt
);
  fwd_tag_t         tag_ex_reg;
  fwd_tag_t         tag_mem_reg;
  fwd_tag_t         tag_ex_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  regbits_t   src_dec [2];
  regbits_t   src_ex  [2];
  logic [1:0] port_en;
  logic [1:0] hit_ex_dec;
  logic [1:0] hit_mem_dec;
  logic [1:0] hit_mem_ex;
  logic [1:0] mex;
  logic [1:0] mmem;

  assign src_dec[PORT_RS] = rs_dec;
  assign src_dec[PORT_RT] = rt_dec;
  assign src_ex[PORT_RS]  = rs_ex;
  assign src_ex[PORT_RT]  = rt_ex;
  assign port_en          = {uses_rt_dec, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      fwd_tag_cmp u_dec_ex (
        .tag (tag_ex_reg),
        .src (src_dec[gi]),
        .hit (hit_ex_dec[gi])
      );
      fwd_tag_cmp u_dec_mem (
        .tag (tag_mem_reg),
        .src (src_dec[gi]),
        .hit (hit_mem_dec[gi])
      );
      fwd_tag_cmp u_ex_mem (
        .tag (tag_mem_reg),
        .src (src_ex[gi]),
        .hit (hit_mem_ex[gi])
      );

      assign mex[gi]         = hit_ex_dec[gi] & port_en[gi];
      assign mmem[gi]        = hit_mem_dec[gi] & port_en[gi];
      assign rport_dec[gi]   = mex[gi] | mmem[gi];
      // The EX-stage producer is younger, so it shadows a MEM match.
      assign sel_mem_dec[gi] = ~mex[gi] & mmem[gi];
      // Only loaded data needs the MEM-stage bypass in execute.
      assign rport_ex[gi]    = hit_mem_ex[gi] & tag_mem_reg.load;
    end
  endgenerate

  assign hazard_dec   = |rport_dec;
  assign hazard_ex    = |rport_ex;
  assign lu_stall     = |mex & tag_ex_reg.load;
  assign MemtoReg_ex  = tag_ex_reg.valid & tag_ex_reg.load;
  assign MemtoReg_mem = tag_mem_reg.valid & tag_mem_reg.load;
  assign stall_cnt    = stall_cnt_reg;

  always_comb begin
    tag_ex_next       = '0;
    tag_ex_next.valid = RegWr_dec;
    tag_ex_next.wsel  = wsel_dec;
    tag_ex_next.load  = MemtoReg_dec;
    if (flush || lu_stall) begin
      tag_ex_next = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_ex_reg    <= '0;
      tag_mem_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (adv) begin
        tag_mem_reg <= tag_ex_reg;
        tag_ex_reg  <= tag_ex_next;
      end
      // Counts stall cycles even while the pipeline is frozen; sticks at max.
      if (lu_stall && !(&stall_cnt_reg)) begin
        stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule
